// File: rtl/int_to_posit_arbiter_if.sv
// Handshake bundle between two integer requesters, the shared posit converter and its consumer.
// The slave modport is the converter's view; the master modport is the environment's view.
interface int_to_posit_arbiter_if #(
    parameter int N = 8,
    parameter int P = 16
);
    logic         a_valid;
    logic [N-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [N-1:0] b_data;
    logic         b_ready;
    logic         out_valid;
    logic [P-1:0] out_posit;
    logic         out_src;
    logic         out_ready;
    logic [15:0]  cnt_a;
    logic [15:0]  cnt_b;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_posit, out_src, cnt_a, cnt_b
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_posit, out_src, cnt_a, cnt_b
    );
endinterface

// File: rtl/int_to_posit_arbiter.sv
// Round-robin arbiter feeding one shared unsigned-int to posit<P,0> converter through a
// two-stage pipeline (S1 = selected operand, S2 = converted result), with per-source counters.
module int_to_posit_arbiter #(
    parameter int N  = 8,
    parameter int P  = 16,
    parameter int ES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    int_to_posit_arbiter_if.slave bus
);
    localparam int KW = $clog2(P) + 1;

    if (ES != 0) begin : g_es_check
        $error("int_to_posit_arbiter supports ES = 0 only");
    end

    logic         s1_valid_q;
    logic [N-1:0] s1_data_q;
    logic         s1_src_q;
    logic         out_valid_q;
    logic [P-1:0] out_posit_q;
    logic         out_src_q;
    logic         ptr_q;
    logic [15:0]  cnt_a_q;
    logic [15:0]  cnt_b_q;

    logic advance;
    logic grant_a;
    logic grant_b;

    // The whole pipeline freezes while the consumer refuses a valid result.
    assign advance = !(out_valid_q && !bus.out_ready);
    assign grant_a = !rst && advance && bus.a_valid && (!bus.b_valid || !ptr_q);
    assign grant_b = !rst && advance && bus.b_valid && (!bus.a_valid || ptr_q);

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_posit = out_posit_q;
    assign bus.out_src   = out_src_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_b     = cnt_b_q;

    logic [KW-1:0] msb_k;
    logic [N-1:0]  x_norm;
    logic [P-2:0]  frac_wide;
    logic [P-2:0]  regime_ones;
    logic [P-2:0]  conv_body;
    logic [P-1:0]  conv_posit;

    // Regime is k+1 ones and a terminating zero; the bits below the leading one of x
    // follow as the fraction, truncated once they run off the end of the word.
    always_comb begin
        msb_k = '0;
        for (int i = 0; i < N; i++) begin
            if (s1_data_q[i]) msb_k = KW'(i);
        end
        x_norm      = s1_data_q << (KW'(N - 1) - msb_k);
        frac_wide   = {x_norm[N-2:0], {(P - N){1'b0}}};
        regime_ones = ~({(P - 1){1'b1}} >> (msb_k + KW'(1)));
        conv_body   = regime_ones | (frac_wide >> (msb_k + KW'(2)));
        conv_posit  = (s1_data_q == '0) ? '0 : {1'b0, conv_body};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_src_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
            out_src_q   <= 1'b0;
            ptr_q       <= 1'b0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            if (advance) begin
                s1_valid_q  <= grant_a || grant_b;
                out_valid_q <= s1_valid_q;
                if (grant_a) begin
                    s1_data_q <= bus.a_data;
                    s1_src_q  <= 1'b0;
                end else if (grant_b) begin
                    s1_data_q <= bus.b_data;
                    s1_src_q  <= 1'b1;
                end
                if (s1_valid_q) begin
                    out_posit_q <= conv_posit;
                    out_src_q   <= s1_src_q;
                end
            end
            if (grant_a) ptr_q <= 1'b1;
            else if (grant_b) ptr_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                if (!out_src_q && cnt_a_q != 16'hFFFF) cnt_a_q <= cnt_a_q + 16'd1;
                if (out_src_q && cnt_b_q != 16'hFFFF) cnt_b_q <= cnt_b_q + 16'd1;
            end
        end
    end
endmodule
